// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcodes, one-hot alu controls, stage occupancy
// and the opcode decode.
package exec_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_INC = 3'd3,
    OP_NEG = 3'd4,
    OP_MOV = 3'd5
  } op_e;

  typedef struct packed {
    logic add;
    logic inc;
    logic neg;
    logic sub;
  } alu_ctrl_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_e;

  // Encodings 6 and 7 fall through to the all-zero (NOP) control word.
  function automatic alu_ctrl_t decode(input op_e op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_MOV: c.add = 1'b1;
      OP_SUB:         c.sub = 1'b1;
      OP_INC:         c.inc = 1'b1;
      OP_NEG:         c.neg = 1'b1;
      default:        c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit alu with one-hot add/inc/neg/sub controls and Z/N flags.
// With no control asserted the result is zero.
module alu #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              add,
  input  logic              inc,
  input  logic              neg,
  input  logic              sub,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              negative
);

  always_comb begin
    result = '0;
    if (add)      result = a + b;
    else if (sub) result = a - b;
    else if (inc) result = a + {{(DATA_W-1){1'b0}}, 1'b1};
    else if (neg) result = '0 - a;
    zero     = (result == '0);
    negative = result[DATA_W-1];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-deep execute stage (S1 operands, S2 result) around the alu, with valid/ready
// backpressure and S1 flush. Define EXEC_OVF_FLAG_EN to add the flag_v overflow output.
module alu_exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
`ifdef EXEC_OVF_FLAG_EN
  output logic              flag_v,
`endif
  output logic              flag_z,
  output logic              flag_n
);

  stage_e            s1_st_q, s1_st_d, s2_st_q, s2_st_d;
  op_e               s1_op_q, s1_op_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [RD_W-1:0]   s1_rd_q, s1_rd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              wen_q, wen_d, z_q, z_d, n_q, n_d;

  logic              s1_v, s2_v, s1_adv, push, move;
  alu_ctrl_t         ctrl;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic              alu_z, alu_n;

  always_comb begin
    s1_v     = (s1_st_q == ST_FULL);
    s2_v     = (s2_st_q == ST_FULL);
    s1_adv   = ~s2_v | out_ready;
    in_ready = ~s1_v | s1_adv;
    push     = in_valid & in_ready & ~flush;
    move     = s1_v & s1_adv & ~flush;
    ctrl     = s1_v ? decode(s1_op_q) : '0;
    alu_b    = (s1_op_q == OP_MOV) ? '0 : s1_b_q;
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .add      (ctrl.add),
    .inc      (ctrl.inc),
    .neg      (ctrl.neg),
    .sub      (ctrl.sub),
    .a        (s1_a_q),
    .b        (alu_b),
    .result   (alu_res),
    .zero     (alu_z),
    .negative (alu_n)
  );

  always_comb begin
    s1_st_d = s1_st_q;
    s1_op_d = s1_op_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_rd_d = s1_rd_q;
    s2_st_d = s2_st_q;
    res_d   = res_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    z_d     = z_q;
    n_d     = n_q;

    // A push may refill S1 in the same cycle its previous op moves into S2.
    if (flush)     s1_st_d = ST_EMPTY;
    else if (push) s1_st_d = ST_FULL;
    else if (move) s1_st_d = ST_EMPTY;

    if (push) begin
      s1_op_d = op_e'(in_opcode);
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      s1_rd_d = in_rd;
    end

    if (move) begin
      s2_st_d = ST_FULL;
      res_d   = alu_res;
      rd_d    = s1_rd_q;
      wen_d   = (ctrl != '0);
      if (ctrl != '0) begin
        z_d = alu_z;
        n_d = alu_n;
      end
    end else if (s2_v & out_ready) begin
      s2_st_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_st_q <= ST_EMPTY;
      s2_st_q <= ST_EMPTY;
      s1_op_q <= OP_NOP;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_rd_q <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      s1_st_q <= s1_st_d;
      s2_st_q <= s2_st_d;
      s1_op_q <= s1_op_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_rd_q <= s1_rd_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

`ifdef EXEC_OVF_FLAG_EN
  logic v_q, v_d, ovf, sa, sb, sr;

  always_comb begin
    sa  = s1_a_q[DATA_W-1];
    sb  = alu_b[DATA_W-1];
    sr  = alu_res[DATA_W-1];
    ovf = (ctrl.add & (sa == sb) & (sr != sa))
        | (ctrl.sub & (sa != sb) & (sr != sa))
        | (ctrl.inc & (s1_a_q == {1'b0, {(DATA_W-1){1'b1}}}))
        | (ctrl.neg & (s1_a_q == {1'b1, {(DATA_W-1){1'b0}}}));
    v_d = (move & (ctrl != '0)) ? ovf : v_q;
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;
  end

  assign flag_v = v_q;
`endif

  assign out_valid  = s2_v;
  assign out_result = res_q;
  assign out_rd     = rd_q;
  assign out_wen    = wen_q;
  assign flag_z     = z_q;
  assign flag_n     = n_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: the driver pushes reference-model results on
// each accepted op; a negedge monitor pops and compares on every output transfer.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [5:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [5:0]  out_rd;
  logic        out_wen;
  logic        flag_z, flag_n;
`ifdef EXEC_OVF_FLAG_EN
  logic        flag_v;
`endif

  alu_exec_stage #(.DATA_W(32), .RD_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
`ifdef EXEC_OVF_FLAG_EN
    .flag_v     (flag_v),
`endif
    .flag_z     (flag_z),
    .flag_n     (flag_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] res;
    bit [5:0]  rd;
    bit        wen;
    bit        z;
    bit        n;
    bit        v;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  bit   mz = 0, mn = 0, mv = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: plain signed/unsigned arithmetic; flags persist across NOPs.
  function automatic exp_t model(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                                 input bit [5:0] rd);
    exp_t   e;
    longint sa, sb, wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.rd = rd;
    e.wen = 1'b1;
    e.res = '0;
    wide = 0;
    case (op)
      3'd1: begin e.res = a + b;  wide = sa + sb; end
      3'd2: begin e.res = a - b;  wide = sa - sb; end
      3'd3: begin e.res = a + 1;  wide = sa + 1;  end
      3'd4: begin e.res = 32'd0 - a; wide = -sa;  end
      3'd5: begin e.res = a;      wide = sa;      end
      default: e.wen = 1'b0;
    endcase
    if (e.wen) begin
      mz = (e.res == 0);
      mn = e.res[31];
      mv = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end
    e.z = mz;
    e.n = mn;
    e.v = mv;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got result %0h rd %0d, expected no output", out_result, out_rd);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd", 64'(out_rd), 64'(e.rd));
        chk("wen", 64'(out_wen), 64'(e.wen));
        if (e.wen) chk("result", 64'(out_result), 64'(e.res));
        chk("flag_z", 64'(flag_z), 64'(e.z));
        chk("flag_n", 64'(flag_n), 64'(e.n));
`ifdef EXEC_OVF_FLAG_EN
        chk("flag_v", 64'(flag_v), 64'(e.v));
`endif
      end
    end
  end

  // Called at posedge+1; returns whether the op transferred at the next edge.
  task automatic send(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                      input bit [5:0] rd, input bit fl, output bit acc);
    bit rdy;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_rd = rd; flush = fl;
    #2 rdy = in_ready;
    @(posedge clk);
    acc = rdy && !fl;
    if (acc) exp_q.push_back(model(op, a, b, rd));
    #1 in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send_wait(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b,
                           input bit [5:0] rd);
    bit acc;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) send(op, a, b, rd, 1'b0, acc);
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic expect_out(input string name, input bit [31:0] res);
    bit seen;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk({name, "_valid"}, 64'(seen), 64'd1);
    if (seen) chk(name, 64'(out_result), 64'(res));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    idle(3);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic bit [31:0] pick_operand();
    bit [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000; corners[4] = 32'hFFFF_FFFF;
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return $urandom();
  endfunction

  initial begin
    bit acc;
    int naccept;

    idle(3);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_rd", 64'(out_rd), 64'd0);
    chk("rst_wen", 64'(out_wen), 64'd0);
    chk("rst_flag_z", 64'(flag_z), 64'd0);
    chk("rst_flag_n", 64'(flag_n), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send_wait(3'd1, 32'd3, 32'd4, 6'd1);
    expect_out("add_3_4", 32'd7);
    send_wait(3'd2, 32'd127, 32'd127, 6'd2);
    expect_out("sub_eq", 32'd0);
    chk("sub_eq_flag_z", 64'(flag_z), 64'd1);
    send_wait(3'd4, 32'd3, 32'd0, 6'd3);
    expect_out("neg_3", 32'hFFFF_FFFD);
    chk("neg_3_flag_n", 64'(flag_n), 64'd1);

    send_wait(3'd3, 32'd5, 32'd0, 6'd4);
    send_wait(3'd5, 32'd9, 32'd55, 6'd5);
    send_wait(3'd0, 32'd1, 32'd2, 6'd6);
    send_wait(3'd7, 32'd1, 32'd2, 6'd7);
    drain();

    out_ready = 1'b0;
    naccept = 0;
    for (int i = 0; i < 3; i++) begin
      send(3'd1, 32'(100 + naccept), 32'd1, 6'(10 + naccept), 1'b0, acc);
      if (acc) naccept++;
    end
    chk("bp_accepted", 64'(naccept), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send_wait(3'd1, 32'(100 + naccept), 32'd1, 6'(10 + naccept));
    drain();

    out_ready = 1'b0;
    send_wait(3'd2, 32'd5, 32'd2, 6'd20);
    idle(1);
    send(3'd1, 32'd1, 32'd1, 6'd21, 1'b0, acc);
    chk("flush_setup_acc", 64'(acc), 64'd1);
    if (acc) void'(exp_q.pop_back());
    mz = 0; mn = 0; mv = 0;
    idle(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    drain();

    send(3'd1, 32'd40, 32'd2, 6'd22, 1'b1, acc);
    drain();

    out_ready = 1'b0;
    send_wait(3'd1, 32'd8, 32'd8, 6'd30);
    send_wait(3'd4, 32'd1, 32'd0, 6'd31);
    rst = 1'b1;
    exp_q.delete();
    mz = 0; mn = 0; mv = 0;
    idle(1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_flag_z", 64'(flag_z), 64'd0);
    chk("midrst_flag_n", 64'(flag_n), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
`ifdef EXEC_OVF_FLAG_EN
    chk("midrst_flag_v", 64'(flag_v), 64'd0);
`endif
    rst = 1'b0;
    out_ready = 1'b1;

`ifdef EXEC_OVF_FLAG_EN
    send_wait(3'd1, 32'h7FFF_FFFF, 32'd1, 6'd32);
    expect_out("ovf_add", 32'h8000_0000);
    chk("ovf_add_flag_v", 64'(flag_v), 64'd1);
    drain();
`endif

    begin
      bit        have;
      bit [2:0]  op;
      bit [31:0] a, b;
      bit [5:0]  rd;
      have = 0;
      for (int i = 0; i < 600; i++) begin
        out_ready = ($urandom_range(3) != 0);
        if (!have && $urandom_range(3) != 0) begin
          have = 1;
          op = 3'($urandom_range(7));
          a = pick_operand();
          b = pick_operand();
          rd = 6'($urandom_range(63));
        end
        if (have) begin
          send(op, a, b, rd, 1'b0, acc);
          if (acc) have = 0;
        end else begin
          idle(1);
        end
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
